// File: rtl/list_pkg.sv
// Shared types and constants for the list feeder/collector family.
package list_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int TYPE_WIDTH_DEF = 32;
   localparam int LEN_WIDTH_DEF  = 16;

   function automatic int log2_ceil(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/list_fifo.sv
// Small synchronous FIFO with registered storage; head reads as zero when empty.
module list_fifo
   import list_pkg::*;
#(
   parameter int TYPE_WIDTH = TYPE_WIDTH_DEF,
   parameter int DEPTH      = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  i_push,
   input  logic [TYPE_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [TYPE_WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int AW = (log2_ceil(DEPTH) < 1) ? 1 : log2_ceil(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   logic [TYPE_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [AW:0]           r_occ;
   logic                  w_wr;
   logic                  w_rd;

   assign o_full  = (r_occ == OCC_FULL);
   assign o_empty = (r_occ == '0);
   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_rd})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/list_collect.sv
// Collects a run of IP results into a FIFO and streams them to the HP write path.
module list_collect
   import list_pkg::*;
#(
   parameter int TYPE_WIDTH = TYPE_WIDTH_DEF,
   parameter int DEPTH      = 4,
   parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic [LEN_WIDTH-1:0]  LENGTH,
   input  logic                  VALID,
   input  logic [TYPE_WIDTH-1:0] ARG_IN,
   output logic                  ACCEPT,
   output logic [TYPE_WIDTH-1:0] LIST_OUT,
   output logic                  PUSH,
   input  logic                  GRANT,
   output logic                  LAST,
   output logic                  DONE,
   output logic [LEN_WIDTH-1:0]  COUNT
);

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_in_cnt;
   logic [LEN_WIDTH-1:0]  r_out_cnt;
   logic                  r_done;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_wr;
   logic                  w_rd;
   logic                  w_last;

   list_fifo #(
      .TYPE_WIDTH (TYPE_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_push  (w_wr),
      .i_data  (ARG_IN),
      .i_pop   (w_rd),
      .o_data  (LIST_OUT),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // ACCEPT uses only registered terms so GRANT never reaches it combinationally.
   assign ACCEPT = (r_state == ST_RUN) && !w_full && (r_in_cnt != r_len);
   assign w_wr   = VALID && ACCEPT;
   assign PUSH   = !w_empty;
   assign w_rd   = PUSH && GRANT;
   assign w_last = PUSH && (r_out_cnt == r_len - 1'b1);
   assign LAST   = w_last;
   assign DONE   = r_done;
   assign COUNT  = r_out_cnt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state   <= ST_IDLE;
         r_len     <= '0;
         r_in_cnt  <= '0;
         r_out_cnt <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_wr) r_in_cnt  <= r_in_cnt + 1'b1;
         if (w_rd) r_out_cnt <= r_out_cnt + 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (START) begin
                  r_len     <= LENGTH;
                  r_in_cnt  <= '0;
                  r_out_cnt <= '0;
                  if (LENGTH == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (w_rd && w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_list_collect.sv
// Directed table-driven bench for list_collect plus multi-cycle corner sequences.
module tb_list_collect;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic [15:0] LENGTH;
   logic        VALID;
   logic [31:0] ARG_IN;
   logic        ACCEPT;
   logic [31:0] LIST_OUT;
   logic        PUSH;
   logic        GRANT;
   logic        LAST;
   logic        DONE;
   logic [15:0] COUNT;

   list_collect #(
      .TYPE_WIDTH (32),
      .DEPTH      (4),
      .LEN_WIDTH  (16)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .LENGTH   (LENGTH),
      .VALID    (VALID),
      .ARG_IN   (ARG_IN),
      .ACCEPT   (ACCEPT),
      .LIST_OUT (LIST_OUT),
      .PUSH     (PUSH),
      .GRANT    (GRANT),
      .LAST     (LAST),
      .DONE     (DONE),
      .COUNT    (COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        start;
      logic [15:0] len;
      logic        valid;
      logic [31:0] arg;
      logic        grant;
      logic        e_acc;
      logic        e_push;
      logic [31:0] e_list;
      logic        e_last;
      logic        e_done;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t        tbl [10];
   int          total;
   int          bad;
   int          k;
   int          rcv;
   int          run_len;
   logic        done_seen;
   logic        acc_s;
   logic [31:0] base_v;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // One cycle of streaming: drive next word, score any pop, count any accept.
   task automatic step();
      ARG_IN = base_v + 32'(k);
      #1;
      acc_s = ACCEPT;
      if (PUSH && GRANT) begin
         chk("data", LIST_OUT, base_v + 32'(rcv));
         chk("last", 32'(LAST), 32'(rcv == run_len - 1));
         rcv++;
      end
      if (DONE) done_seen = 1'b1;
      if (VALID && acc_s) k++;
   endtask

   task automatic run_until_done(input int max_cyc);
      for (int c = 0; c < max_cyc && !done_seen; c++) begin
         @(negedge CLK);
         START = 1'b0;
         step();
      end
   endtask

   initial begin
      total = 0; bad = 0; k = 0; rcv = 0; run_len = 0;
      done_seen = 1'b0; acc_s = 1'b0; base_v = '0;
      RESET = 1'b0; START = 1'b0; LENGTH = '0; VALID = 1'b0;
      ARG_IN = '0; GRANT = 1'b0;

      tbl[0] = '{1'b1, 16'd3, 1'b1, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0};
      tbl[1] = '{1'b0, 16'd3, 1'b1, 32'hA, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0};
      tbl[2] = '{1'b0, 16'd3, 1'b1, 32'hB, 1'b1, 1'b1, 1'b1, 32'hA, 1'b0, 1'b0, 16'd0};
      tbl[3] = '{1'b0, 16'd3, 1'b1, 32'hC, 1'b1, 1'b1, 1'b1, 32'hB, 1'b0, 1'b0, 16'd1};
      tbl[4] = '{1'b0, 16'd3, 1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 1'b0, 16'd2};
      tbl[5] = '{1'b1, 16'd7, 1'b1, 32'hD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd3};
      tbl[6] = '{1'b0, 16'd0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd3};
      tbl[7] = '{1'b1, 16'd0, 1'b1, 32'hE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd3};
      tbl[8] = '{1'b0, 16'd0, 1'b1, 32'hE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 16'd0};
      tbl[9] = '{1'b0, 16'd0, 1'b1, 32'hE, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'd0};

      #12;
      chk("rst_acc",   32'(ACCEPT), 32'd0);
      chk("rst_push",  32'(PUSH),   32'd0);
      chk("rst_list",  LIST_OUT,    32'd0);
      chk("rst_last",  32'(LAST),   32'd0);
      chk("rst_done",  32'(DONE),   32'd0);
      chk("rst_count", 32'(COUNT),  32'd0);
      @(negedge CLK);
      RESET = 1'b1;

      // Basic LENGTH=3 run, DONE-state START ignore, then a zero-length run.
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         START  = tbl[i].start;
         LENGTH = tbl[i].len;
         VALID  = tbl[i].valid;
         ARG_IN = tbl[i].arg;
         GRANT  = tbl[i].grant;
         #1;
         chk($sformatf("v%0d_acc", i),   32'(ACCEPT), 32'(tbl[i].e_acc));
         chk($sformatf("v%0d_push", i),  32'(PUSH),   32'(tbl[i].e_push));
         chk($sformatf("v%0d_list", i),  LIST_OUT,    tbl[i].e_list);
         chk($sformatf("v%0d_last", i),  32'(LAST),   32'(tbl[i].e_last));
         chk($sformatf("v%0d_done", i),  32'(DONE),   32'(tbl[i].e_done));
         chk($sformatf("v%0d_count", i), 32'(COUNT),  32'(tbl[i].e_cnt));
      end

      // Back-pressure: LENGTH=6 with GRANT low fills the FIFO.
      @(negedge CLK);
      START = 1'b1; LENGTH = 16'd6; VALID = 1'b0; GRANT = 1'b0;
      k = 0; rcv = 0; run_len = 6; base_v = 32'h10; done_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         START = 1'b0; VALID = 1'b1;
         step();
      end
      chk("bp_accepts", 32'(k),      32'd4);
      chk("bp_acc_low", 32'(ACCEPT), 32'd0);
      chk("bp_push",    32'(PUSH),   32'd1);
      chk("bp_hold",    LIST_OUT,    32'h10);
      chk("bp_last",    32'(LAST),   32'd0);

      // Full with simultaneous pop: ACCEPT stays low this cycle, returns next.
      @(negedge CLK);
      GRANT = 1'b1;
      step();
      chk("fp_acc_low", 32'(acc_s), 32'd0);
      @(negedge CLK);
      step();
      chk("fp_acc_back", 32'(acc_s), 32'd1);
      run_until_done(40);
      chk("bp_done",  32'(done_seen), 32'd1);
      chk("bp_rcv",   32'(rcv),       32'd6);
      chk("bp_in",    32'(k),         32'd6);
      chk("bp_count", 32'(COUNT),     32'd6);
      chk("bp_empty", 32'(PUSH),      32'd0);

      // Overrun guard: LENGTH=2, IP keeps offering, START pulsed again in RUN.
      @(negedge CLK);
      START = 1'b1; LENGTH = 16'd2; VALID = 1'b0; GRANT = 1'b1;
      k = 0; rcv = 0; run_len = 2; base_v = 32'h21; done_seen = 1'b0;
      @(negedge CLK);
      START = 1'b1; LENGTH = 16'd9; VALID = 1'b1;
      step();
      run_until_done(40);
      chk("ov_done",    32'(done_seen), 32'd1);
      chk("ov_in",      32'(k),         32'd2);
      chk("ov_rcv",     32'(rcv),       32'd2);
      chk("ov_acc_dn",  32'(ACCEPT),    32'd0);
      chk("ov_count",   32'(COUNT),     32'd2);
      @(negedge CLK);
      step();
      chk("ov_acc_idle", 32'(acc_s),    32'd0);
      chk("ov_in_idle",  32'(k),        32'd2);

      // Asynchronous reset mid-run, then a fresh LENGTH=2 run.
      @(negedge CLK);
      START = 1'b1; LENGTH = 16'd5; VALID = 1'b0; GRANT = 1'b1;
      k = 0; rcv = 0; run_len = 5; base_v = 32'h31; done_seen = 1'b0;
      @(negedge CLK);
      START = 1'b0; VALID = 1'b1;
      step();
      @(negedge CLK);
      step();
      @(negedge CLK);
      #1;
      chk("ar_pre_push",  32'(PUSH),  32'd1);
      chk("ar_pre_list",  LIST_OUT,   32'h32);
      chk("ar_pre_count", 32'(COUNT), 32'd1);
      RESET = 1'b0;
      #1;
      chk("ar_acc",   32'(ACCEPT), 32'd0);
      chk("ar_push",  32'(PUSH),   32'd0);
      chk("ar_list",  LIST_OUT,    32'd0);
      chk("ar_last",  32'(LAST),   32'd0);
      chk("ar_done",  32'(DONE),   32'd0);
      chk("ar_count", 32'(COUNT),  32'd0);
      @(negedge CLK);
      RESET = 1'b1; VALID = 1'b0;
      @(negedge CLK);
      START = 1'b1; LENGTH = 16'd2;
      k = 0; rcv = 0; run_len = 2; base_v = 32'h41; done_seen = 1'b0;
      @(negedge CLK);
      START = 1'b0; VALID = 1'b1;
      step();
      run_until_done(40);
      chk("ar2_done",  32'(done_seen), 32'd1);
      chk("ar2_rcv",   32'(rcv),       32'd2);
      chk("ar2_in",    32'(k),         32'd2);
      chk("ar2_count", 32'(COUNT),     32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/list_collect.md
Name: list_collect

Overview:
- Result-side counterpart of the list feeder: collects a list of TYPE_WIDTH results from the compute IP and streams them back toward the HP port as an ordered list.
- Sits between the IP output (VALID/ARG_IN) and the HP write path (PUSH/GRANT).
- Buffers results in a small FIFO so the IP is not stalled by short HP back-pressure.
- A run is started with a programmed length and reports completion with DONE.

Parameters:
- TYPE_WIDTH, 32, width of one list element.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- LEN_WIDTH, 16, width of the list length and counters.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- START  in  1  begin a run; sampled only in IDLE.
- LENGTH  in  LEN_WIDTH  number of elements in the run; latched on START.
- VALID  in  1  IP presents ARG_IN.
- ARG_IN  in  TYPE_WIDTH  result element from the IP.
- ACCEPT  out  1  block takes ARG_IN this cycle when VALID && ACCEPT.
- LIST_OUT  out  TYPE_WIDTH  element toward the HP port (FIFO head).
- PUSH  out  1  LIST_OUT is valid.
- GRANT  in  1  HP side takes LIST_OUT when PUSH && GRANT.
- LAST  out  1  LIST_OUT is element LENGTH-1.
- DONE  out  1  one-cycle pulse when the run completes.
- COUNT  out  LEN_WIDTH  elements delivered to the HP side in the current run.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State = IDLE; FIFO emptied; all counters = 0.
  - ACCEPT = PUSH = LAST = DONE = 0; COUNT = 0; LIST_OUT = 0.
- Reset mid-run aborts the run immediately and discards all buffered data.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when START = 1 and LENGTH != 0. LENGTH is latched; the input and output counters clear.
  - IDLE -> DONE when START = 1 and LENGTH == 0. No data moves.
  - RUN -> DONE on the output transfer where LAST = 1.
  - DONE -> IDLE unconditionally after 1 cycle. DONE = 1 only while in the DONE state.
  - START is ignored outside IDLE.
- Input side:
  - ACCEPT = (state == RUN) && !full && (in_cnt != len). It is decoded from registers only and does not depend on VALID or GRANT.
  - When VALID && ACCEPT: write ARG_IN into the FIFO and increment in_cnt.
  - VALID while ACCEPT = 0 is held off. It is never dropped or counted.
- Output side:
  - PUSH = !empty.
  - LIST_OUT = FIFO head. LIST_OUT is 0 when the FIFO is empty.
  - LAST = PUSH && (out_cnt == len - 1).
  - On PUSH && GRANT: pop the FIFO and increment out_cnt. COUNT = out_cnt.
  - While PUSH && !GRANT, LIST_OUT, PUSH and LAST hold stable.
- Latency: an element accepted at edge N is on LIST_OUT after edge N (next cycle) if the FIFO was empty. Throughput is 1 element/cycle sustained.
- Simultaneous write and read:
  - Allowed in the same cycle; occupancy is unchanged.
  - When full, ACCEPT = 0 even if a pop occurs in that cycle, so there is no combinational path from GRANT to ACCEPT.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is DEPTH+1-valued, 0..DEPTH.
- Counters are LEN_WIDTH bits. LENGTH up to 2^LEN_WIDTH-1 is legal; counters never wrap within a run.
- FIFO is empty at the end of every run. COUNT holds its final value until the next START.

Decomposition:
- list_pkg holds:
  - the state typedef (IDLE/RUN/DONE),
  - the default TYPE_WIDTH/LEN_WIDTH constants, shared with list_cache,
  - a log2 helper for DEPTH.
- One sub-module, list_fifo (parameters TYPE_WIDTH, DEPTH), provides push/pop/full/empty with a registered array.
- The run FSM and counters live in list_collect.

Test Plan:
- Basic run: LENGTH=3, VALID held high with ARG_IN 0xA, 0xB, 0xC, GRANT=1 -> LIST_OUT A, B, C on consecutive cycles, each 1 cycle after accept; LAST with C; DONE pulses the cycle after C; COUNT=3.
- Back-pressure: LENGTH=6, DEPTH=4, GRANT=0 -> ACCEPT drops after 4 accepts and LIST_OUT holds the first element. Then GRANT=1 -> all 6 elements arrive in order with none lost or duplicated; ACCEPT returns the cycle after the first pop.
- Zero length: START with LENGTH=0 -> ACCEPT and PUSH stay 0; DONE pulses 1 cycle later; COUNT=0.
- Full with simultaneous pop: FIFO full, VALID=1, GRANT=1 -> ACCEPT=0 that cycle, occupancy goes to 3, ACCEPT=1 the next cycle.
- Overrun guard: LENGTH=2 and the IP presents 3 VALID words -> only 2 are accepted; the 3rd word stays un-accepted while ACCEPT=0 through DONE; START is ignored while in RUN.
- Async reset mid-run: after 2 of 5 elements, assert RESET=0 between clock edges -> outputs go to 0 immediately without a clock edge; a subsequent run with LENGTH=2 returns only the new data.
